// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with a built-in test-pattern source for the HDMI transmit path.
// Counters walk active/front-porch/sync/back-porch; all outputs are registered one clock behind the counters.
module video_timing_pattern_gen #(
   parameter int          H_ACTIVE    = 640,
   parameter int          H_FP        = 16,
   parameter int          H_SYNC      = 96,
   parameter int          H_BP        = 48,
   parameter int          V_ACTIVE    = 480,
   parameter int          V_FP        = 10,
   parameter int          V_SYNC      = 2,
   parameter int          V_BP        = 33,
   parameter int          HS_POL      = 0,
   parameter int          VS_POL      = 0,
   parameter int          COLOR_WIDTH = 8,
   parameter int          CHECK_LOG2  = 4,
   parameter logic [23:0] SOLID_RGB   = 24'hFFFFFF
) (
   input  logic                   clock_25,
   input  logic                   reset_n,
   input  logic [3:0]             mode,
   output logic                   data_enable,
   output logic                   horz_sync,
   output logic                   vert_sync,
   output logic [COLOR_WIDTH-1:0] red,
   output logic [COLOR_WIDTH-1:0] green,
   output logic [COLOR_WIDTH-1:0] blue,
   output logic [11:0]            pixel_x,
   output logic [11:0]            pixel_y,
   output logic                   frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // 13-bit bounds so a 4096-count line/frame still compares correctly
   localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
   localparam logic [12:0] HS_BEG    = 13'(H_ACTIVE + H_FP);
   localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
   localparam logic [12:0] VS_BEG    = 13'(V_ACTIVE + V_FP);
   localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);

   localparam int          BAR_W     = H_ACTIVE / 8;
   localparam logic [11:0] BAR_LAST  = 12'(BAR_W - 1);

   localparam logic HS_ON = (HS_POL != 0);
   localparam logic VS_ON = (VS_POL != 0);

   localparam logic [COLOR_WIDTH-1:0] SOLID_R = SOLID_RGB[23 -: COLOR_WIDTH];
   localparam logic [COLOR_WIDTH-1:0] SOLID_G = SOLID_RGB[15 -: COLOR_WIDTH];
   localparam logic [COLOR_WIDTH-1:0] SOLID_B = SOLID_RGB[7  -: COLOR_WIDTH];
   localparam logic [COLOR_WIDTH-1:0] FULL    = {COLOR_WIDTH{1'b1}};

   localparam logic [3:0] MODE_SOLID   = 4'd0;
   localparam logic [3:0] MODE_BARS    = 4'd1;
   localparam logic [3:0] MODE_CHECKER = 4'd2;
   localparam logic [3:0] MODE_GRAD    = 4'd3;

   // Counter state
   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;
   logic [11:0] bar_cnt_q, bar_cnt_d;
   logic [2:0]  bar_idx_q, bar_idx_d;
   logic [3:0]  mode_q, mode_d;

   logic h_wrap;
   logic at_origin;

   // Pixel decode
   logic                   active;
   logic                   hs_act;
   logic                   vs_act;
   logic                   check_cell;
   logic [COLOR_WIDTH-1:0] pat_r, pat_g, pat_b;

   // Output registers
   logic                   de_q, de_d;
   logic                   hs_q, hs_d;
   logic                   vs_q, vs_d;
   logic [COLOR_WIDTH-1:0] r_q, r_d;
   logic [COLOR_WIDTH-1:0] g_q, g_d;
   logic [COLOR_WIDTH-1:0] b_q, b_d;
   logic [11:0]            px_q, px_d;
   logic [11:0]            py_q, py_d;
   logic                   fs_q, fs_d;

   always_comb begin
      h_wrap    = (h_cnt_q == H_LAST);
      at_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

      h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
      end

      // The origin pixel already uses the freshly sampled mode
      mode_d = at_origin ? mode : mode_q;
   end

   // Bar index tracks h_cnt / BAR_W incrementally, saturating at the last bar
   always_comb begin
      bar_cnt_d = bar_cnt_q + 12'd1;
      bar_idx_d = bar_idx_q;
      if (h_wrap) begin
         bar_cnt_d = 12'd0;
         bar_idx_d = 3'd0;
      end else if (bar_cnt_q == BAR_LAST) begin
         bar_cnt_d = 12'd0;
         if (bar_idx_q != 3'd7) begin
            bar_idx_d = bar_idx_q + 3'd1;
         end
      end
   end

   always_comb begin
      active = ({1'b0, h_cnt_q} < H_ACT_END) && ({1'b0, v_cnt_q} < V_ACT_END);
      hs_act = ({1'b0, h_cnt_q} >= HS_BEG) && ({1'b0, h_cnt_q} < HS_END);
      vs_act = ({1'b0, v_cnt_q} >= VS_BEG) && ({1'b0, v_cnt_q} < VS_END);
      check_cell = h_cnt_q[CHECK_LOG2] ^ v_cnt_q[CHECK_LOG2];
   end

   // Bar order white..black maps to r=~idx[1], g=~idx[2], b=~idx[0]
   always_comb begin
      pat_r = '0;
      pat_g = '0;
      pat_b = '0;
      case (mode_d)
         MODE_SOLID: begin
            pat_r = SOLID_R;
            pat_g = SOLID_G;
            pat_b = SOLID_B;
         end
         MODE_BARS: begin
            pat_r = {COLOR_WIDTH{~bar_idx_q[1]}};
            pat_g = {COLOR_WIDTH{~bar_idx_q[2]}};
            pat_b = {COLOR_WIDTH{~bar_idx_q[0]}};
         end
         MODE_CHECKER: begin
            pat_r = check_cell ? '0 : FULL;
            pat_g = check_cell ? '0 : FULL;
            pat_b = check_cell ? '0 : FULL;
         end
         MODE_GRAD: begin
            pat_r = h_cnt_q[COLOR_WIDTH-1:0];
            pat_g = h_cnt_q[COLOR_WIDTH-1:0];
            pat_b = h_cnt_q[COLOR_WIDTH-1:0];
         end
         default: begin
            pat_r = '0;
            pat_g = '0;
            pat_b = '0;
         end
      endcase
   end

   always_comb begin
      de_d = active;
      hs_d = hs_act ? HS_ON : ~HS_ON;
      vs_d = vs_act ? VS_ON : ~VS_ON;
      r_d  = active ? pat_r : '0;
      g_d  = active ? pat_g : '0;
      b_d  = active ? pat_b : '0;
      px_d = h_cnt_q;
      py_d = v_cnt_q;
      fs_d = at_origin;
   end

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         bar_cnt_q <= '0;
         bar_idx_q <= '0;
         mode_q    <= '0;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         bar_cnt_q <= bar_cnt_d;
         bar_idx_q <= bar_idx_d;
         mode_q    <= mode_d;
      end
   end

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         de_q <= 1'b0;
         hs_q <= ~HS_ON;
         vs_q <= ~VS_ON;
         r_q  <= '0;
         g_q  <= '0;
         b_q  <= '0;
         px_q <= '0;
         py_q <= '0;
         fs_q <= 1'b0;
      end else begin
         de_q <= de_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
         r_q  <= r_d;
         g_q  <= g_d;
         b_q  <= b_d;
         px_q <= px_d;
         py_q <= py_d;
         fs_q <= fs_d;
      end
   end

   assign data_enable = de_q;
   assign horz_sync   = hs_q;
   assign vert_sync   = vs_q;
   assign red         = r_q;
   assign green       = g_q;
   assign blue        = b_q;
   assign pixel_x     = px_q;
   assign pixel_y     = py_q;
   assign frame_start = fs_q;

endmodule
